// File: rtl/array_ram_bytewr.sv
// Single-port-write / single-port-read word array with byte-lane enables, selectable
// collision policy and a post-reset zeroing sequencer. Optional macro: ARRAY_OUT_REG_EN.
module array_ram_bytewr #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 16,
  parameter int BYTE           = 8,
  parameter int RD_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = WIDTH / BYTE,
  localparam int ADDR          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_en,
  input  logic [ADDR-1:0]  write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [NB-1:0]    write_be,
  input  logic             read_en,
  input  logic [ADDR-1:0]  read_addr,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  output logic             busy
);

  localparam logic [ADDR-1:0] LAST    = ADDR'(DEPTH - 1);
  localparam logic [ADDR:0]   DEPTH_W = (ADDR + 1)'(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, state_next;
  logic [ADDR-1:0]  ptr, ptr_next;
  logic             clr_we;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_ok, rd_ok, wr_in_range, rd_in_range;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] data_s1;
  logic             valid_s1;

  assign busy        = (state == CLEAR);
  assign wr_in_range = ({1'b0, write_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, read_addr} < DEPTH_W);
  assign wr_ok       = (state == READY) && write_en && wr_in_range;
  assign rd_ok       = (state == READY) && read_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    clr_we     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we   = 1'b1;
        ptr_next = ptr + 1'b1;
        if (ptr == LAST) begin
          state_next = READY;
          ptr_next   = '0;
        end
      end
      READY:   state_next = READY;
      default: state_next = READY;
    endcase
  end

  // Array has no reset; zeroing happens only through the clear sequencer.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (write_be[b]) mem[write_addr][b*BYTE +: BYTE] <= write_data[b*BYTE +: BYTE];
      end
    end
  end

  // Out-of-range reads return zero; write-first forwards the enabled lanes.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[read_addr];
      if (RD_MODE == 1 && wr_ok && write_addr == read_addr) begin
        for (int b = 0; b < NB; b++) begin
          if (write_be[b]) rd_word[b*BYTE +: BYTE] = write_data[b*BYTE +: BYTE];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_s1  <= '0;
      valid_s1 <= 1'b0;
    end else begin
      valid_s1 <= rd_ok;
      if (rd_ok) data_s1 <= rd_word;
    end
  end

`ifdef ARRAY_OUT_REG_EN
  logic [WIDTH-1:0] data_s2;
  logic             valid_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_s2  <= '0;
      valid_s2 <= 1'b0;
    end else begin
      valid_s2 <= valid_s1;
      if (valid_s1) data_s2 <= data_s1;
    end
  end

  assign read_data  = data_s2;
  assign read_valid = valid_s2;
`else
  assign read_data  = data_s1;
  assign read_valid = valid_s1;
`endif

endmodule

// File: tb/tb_array_ram_bytewr.sv
// Bench for array_ram_bytewr: two instances (DEPTH=16 read-first, DEPTH=12 write-first)
// share one directed stimulus stream and are checked against a word-level model.
module tb_array_ram_bytewr;

`ifdef ARRAY_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEP  [2] = '{16, 12};
  localparam int MODE [2] = '{0, 1};

  // Handshake: a request is taken on a posedge when its enable is high and busy is low;
  // its data appears with read_valid LAT edges later, read_data holds otherwise.

  // ---------------- clock / reset / inputs ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_en, read_en;
  logic [3:0]  write_addr, read_addr, write_be;
  logic [31:0] write_data;
  always #5 clk = ~clk;

  logic [31:0] rd_a, rd_b;
  logic        rv_a, rv_b, busy_a, busy_b;

  array_ram_bytewr #(.WIDTH(32), .DEPTH(16), .BYTE(8), .RD_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .write_be(write_be), .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_a), .read_valid(rv_a), .busy(busy_a));

  array_ram_bytewr #(.WIDTH(32), .DEPTH(12), .BYTE(8), .RD_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .write_be(write_be), .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_b), .read_valid(rv_b), .busy(busy_b));

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mmem [2][16];
  int          clr_left [2];
  logic        pv [2][2];
  logic [31:0] pd [2][2];
  logic [31:0] exp_q [$];
  logic        m_valid [2];
  logic [31:0] m_data [2];
  logic        e_valid [2];
  logic [31:0] e_data [2];
  logic        e_busy [2];
  logic        started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level view: clear takes DEPTH edges, reads see the pre-edge array (or the merged
  // word in write-first mode), results surface LAT edges later and the last one is held.
  task automatic model_step();
    logic        acc;
    logic [31:0] val, nw;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        clr_left[k] = DEP[k];
        for (int j = 0; j < 2; j++) begin pv[k][j] = 1'b0; pd[k][j] = '0; end
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
      end else begin
        acc = 1'b0;
        val = '0;
        if (clr_left[k] > 0) begin
          mmem[k][DEP[k] - clr_left[k]] = '0;
          clr_left[k]--;
        end else begin
          if (read_en) begin
            acc = 1'b1;
            if (int'(read_addr) < DEP[k]) val = mmem[k][read_addr];
          end
          if (write_en && int'(write_addr) < DEP[k]) begin
            nw = mmem[k][write_addr];
            for (int b = 0; b < 4; b++) if (write_be[b]) nw[b*8 +: 8] = write_data[b*8 +: 8];
            if (MODE[k] == 1 && read_en && read_addr == write_addr) val = nw;
            mmem[k][write_addr] = nw;
          end
        end
        for (int j = LAT - 1; j > 0; j--) begin pv[k][j] = pv[k][j-1]; pd[k][j] = pd[k][j-1]; end
        pv[k][0] = acc;
        pd[k][0] = val;
        m_valid[k] = pv[k][LAT-1];
        if (pv[k][LAT-1]) m_data[k] = pd[k][LAT-1];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      e_valid[k] = m_valid[k];
      e_data[k]  = m_data[k];
      e_busy[k]  = (clr_left[k] != 0);
    end
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    write_en = 1'b0;
    read_en  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    write_en = 1'b1; write_addr = a; write_data = d; write_be = be; read_en = 1'b0;
    tick();
    write_en = 1'b0;
  endtask

  task automatic do_rd(input logic [3:0] a);
    read_en = 1'b1; read_addr = a; write_en = 1'b0;
    tick();
    read_en = 1'b0;
  endtask

  // Literal expectation at the read-result cycle for both instances.
  task automatic lit(input string name, input logic [31:0] ea, input logic [31:0] eb);
    chk({name, " a data"}, rd_a, ea);
    chk({name, " b data"}, rd_b, eb);
    chk({name, " a valid"}, {31'b0, rv_a}, 32'd1);
    chk({name, " b valid"}, {31'b0, rv_b}, 32'd1);
  endtask

  task automatic rd_lit(input string name, input logic [3:0] a, input logic [31:0] ea,
                        input logic [31:0] eb);
    do_rd(a);
    idle(LAT - 1);
    lit(name, ea, eb);
  endtask

  // Counts cycles with busy high; requests (addr 2, 0xDEADBEEF) are driven for n_req of them.
  task automatic count_busy(input int n_req, output int cnt_a, output int cnt_b);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (!busy_a && !busy_b) break;
      write_en = (i < n_req); read_en = (i < n_req);
      write_addr = 4'd2; read_addr = 4'd2; write_data = 32'hDEADBEEF; write_be = 4'hF;
      tick();
    end
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("a busy",  {31'b0, busy_a}, {31'b0, e_busy[0]});
        chk("b busy",  {31'b0, busy_b}, {31'b0, e_busy[1]});
        chk("a valid", {31'b0, rv_a},   {31'b0, e_valid[0]});
        chk("b valid", {31'b0, rv_b},   {31'b0, e_valid[1]});
        chk("a data",  rd_a, e_data[0]);
        chk("b data",  rd_b, e_data[1]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int ca, cb;
    rst_n = 1'b0; write_en = 1'b0; read_en = 1'b0;
    write_addr = '0; read_addr = '0; write_data = '0; write_be = '0;

    // 1. reset, clear length, all-zero readback
    tick(); tick();
    chk("reset a data", rd_a, 32'h0);
    chk("reset a valid", {31'b0, rv_a}, 32'd0);
    rst_n = 1'b1;
    count_busy(0, ca, cb);
    chk("clear len a", ca, 32'd16);
    chk("clear len b", cb, 32'd12);
    for (int i = 0; i < 16; i++) do_rd(4'(i));
    idle(LAT);

    // 2. full-word fill and readback (b drops 12..15, reads of those give 0)
    for (int i = 0; i < 16; i++) do_wr(4'(i), i * 32'h01010101, 4'hF);
    for (int i = 0; i < 16; i++) do_rd(4'(i));
    idle(LAT);
    rd_lit("fill 9", 4'd9, 32'h09090909, 32'h09090909);
    rd_lit("fill 14", 4'd14, 32'h0E0E0E0E, 32'h0);

    // 3. byte lanes
    do_wr(4'd3, 32'hAABBCCDD, 4'hF);
    do_wr(4'd3, 32'h11223344, 4'b0101);
    rd_lit("lanes", 4'd3, 32'hAA22CC44, 32'hAA22CC44);
    do_wr(4'd3, 32'h55667788, 4'h0);
    rd_lit("be zero", 4'd3, 32'hAA22CC44, 32'hAA22CC44);

    // 4. collision, then a plain follow-up read; also a different-address pair
    do_wr(4'd5, 32'h12345678, 4'hF);
    write_en = 1'b1; write_addr = 4'd5; write_data = 32'hFFFFFFFF; write_be = 4'b0011;
    read_en = 1'b1; read_addr = 4'd5;
    tick();
    idle(LAT - 1);
    lit("collide", 32'h12345678, 32'h1234FFFF);
    rd_lit("after collide", 4'd5, 32'h1234FFFF, 32'h1234FFFF);
    write_en = 1'b1; write_addr = 4'd8; write_data = 32'hCAFE0008; write_be = 4'hF;
    read_en = 1'b1; read_addr = 4'd9;
    tick();
    idle(LAT - 1);
    lit("no interact", 32'h09090909, 32'h09090909);
    rd_lit("other addr", 4'd8, 32'hCAFE0008, 32'hCAFE0008);
    for (int i = 0; i < 8; i++) begin
      write_en = 1'b1; write_addr = 4'(i + 4); write_data = 32'hB0B0_0000 + i; write_be = 4'hF;
      read_en = 1'b1; read_addr = 4'(i + 5);
      tick();
    end
    idle(LAT);

    // 6. idle hold and out-of-range
    do_wr(4'd7, 32'h0A0B0C0D, 4'hF);
    rd_lit("hold src", 4'd7, 32'h0A0B0C0D, 32'h0A0B0C0D);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("hold a valid", {31'b0, rv_a}, 32'd0);
      chk("hold b valid", {31'b0, rv_b}, 32'd0);
      chk("hold a data", rd_a, 32'h0A0B0C0D);
      chk("hold b data", rd_b, 32'h0A0B0C0D);
    end
    do_wr(4'd13, 32'hCAFEF00D, 4'hF);
    rd_lit("range 13", 4'd13, 32'hCAFEF00D, 32'h0);

    // 5. reset mid-clear, requests ignored while busy
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy(10, ca, cb);
    chk("reclear len a", ca, 32'd16);
    chk("reclear len b", cb, 32'd12);
    rd_lit("ignored wr", 4'd2, 32'h0, 32'h0);
    rd_lit("cleared 13", 4'd13, 32'h0, 32'h0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
